// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates one entry per issued instruction, gathers
// out-of-order ALU/LSB results and retires strictly in program order.
module reorder_buffer #(
    parameter int ROB_SIZE = 16,
    localparam int PW = $clog2(ROB_SIZE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rdy,
    input  logic          issue_en,
    input  logic [1:0]    issue_type,
    input  logic [4:0]    issue_rd,
    input  logic [31:0]   issue_pc,
    input  logic          issue_pre_j,
    input  logic          issue_ready,
    input  logic [31:0]   issue_val,
    output logic [PW-1:0] rob_pos,
    output logic          rob_full,
    input  logic          alu_en,
    input  logic [PW-1:0] alu_rob_pos,
    input  logic [31:0]   alu_val,
    input  logic          alu_res_j,
    input  logic [31:0]   alu_res_pc,
    input  logic          lsb_en,
    input  logic [PW-1:0] lsb_rob_pos,
    input  logic [31:0]   lsb_val,
    input  logic [PW-1:0] q1_pos,
    output logic          q1_rdy,
    output logic [31:0]   q1_val,
    input  logic [PW-1:0] q2_pos,
    output logic          q2_rdy,
    output logic [31:0]   q2_val,
    output logic          reg_en,
    output logic [4:0]    reg_rd,
    output logic [31:0]   reg_val,
    output logic [PW-1:0] reg_rob_pos,
    output logic          st_commit_en,
    output logic [PW-1:0] st_commit_pos,
    output logic          br_en,
    output logic          br_j,
    output logic [31:0]   br_pc,
    output logic          rollback,
    output logic [31:0]   rollback_pc
);

    localparam logic [1:0]    TYPE_REG  = 2'd0;
    localparam logic [1:0]    TYPE_BR   = 2'd1;
    localparam logic [1:0]    TYPE_ST   = 2'd2;
    localparam logic [1:0]    TYPE_JALR = 2'd3;
    localparam logic [PW-1:0] POS_ONE   = PW'(1);
    localparam logic [PW:0]   CNT_ONE   = (PW+1)'(1);
    localparam logic [PW:0]   FULL_CNT  = (PW+1)'(ROB_SIZE - 1);

    logic [ROB_SIZE-1:0] ent_valid;
    logic [ROB_SIZE-1:0] ent_ready;
    logic [ROB_SIZE-1:0] ent_pre_j;
    logic [ROB_SIZE-1:0] ent_res_j;
    logic [1:0]          ent_type   [ROB_SIZE];
    logic [4:0]          ent_rd     [ROB_SIZE];
    logic [31:0]         ent_pc     [ROB_SIZE];
    logic [31:0]         ent_val    [ROB_SIZE];
    logic [31:0]         ent_res_pc [ROB_SIZE];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW:0]   count;

    logic          do_commit;
    logic          c_reg_en;
    logic [4:0]    c_reg_rd;
    logic [31:0]   c_reg_val;
    logic [PW-1:0] c_reg_pos;
    logic          c_st_en;
    logic [PW-1:0] c_st_pos;
    logic          c_br_en;
    logic          c_br_j;
    logic [31:0]   c_br_pc;
    logic          c_rb;
    logic [31:0]   c_rb_pc;

    logic alu_hit;
    logic lsb_hit;

    assign rob_pos  = tail;
    assign rob_full = (count >= FULL_CNT);

    // Bus bypass lets the decoder see a result in the same cycle it is broadcast.
    assign q1_rdy = (alu_en && alu_rob_pos == q1_pos) || (lsb_en && lsb_rob_pos == q1_pos)
                    || ent_ready[q1_pos];
    assign q1_val = (alu_en && alu_rob_pos == q1_pos) ? alu_val :
                    (lsb_en && lsb_rob_pos == q1_pos) ? lsb_val : ent_val[q1_pos];
    assign q2_rdy = (alu_en && alu_rob_pos == q2_pos) || (lsb_en && lsb_rob_pos == q2_pos)
                    || ent_ready[q2_pos];
    assign q2_val = (alu_en && alu_rob_pos == q2_pos) ? alu_val :
                    (lsb_en && lsb_rob_pos == q2_pos) ? lsb_val : ent_val[q2_pos];

    assign alu_hit = alu_en && ent_valid[alu_rob_pos];
    assign lsb_hit = lsb_en && ent_valid[lsb_rob_pos];

    always_comb begin
        do_commit = ent_valid[head] && ent_ready[head];
        c_reg_en  = 1'b0;
        c_reg_rd  = '0;
        c_reg_val = '0;
        c_reg_pos = '0;
        c_st_en   = 1'b0;
        c_st_pos  = '0;
        c_br_en   = 1'b0;
        c_br_j    = 1'b0;
        c_br_pc   = '0;
        c_rb      = 1'b0;
        c_rb_pc   = '0;
        if (do_commit) begin
            case (ent_type[head])
                TYPE_REG, TYPE_JALR: begin
                    c_reg_en  = 1'b1;
                    c_reg_rd  = ent_rd[head];
                    c_reg_val = ent_val[head];
                    c_reg_pos = head;
                    if (ent_type[head] == TYPE_JALR) begin
                        c_rb    = 1'b1;
                        c_rb_pc = ent_res_pc[head];
                    end
                end
                TYPE_ST: begin
                    c_st_en  = 1'b1;
                    c_st_pos = head;
                end
                TYPE_BR: begin
                    c_br_en = 1'b1;
                    c_br_j  = ent_res_j[head];
                    c_br_pc = ent_pc[head];
                    // Mispredict: redirect to the path the branch actually took.
                    if (ent_res_j[head] != ent_pre_j[head]) begin
                        c_rb    = 1'b1;
                        c_rb_pc = ent_res_j[head] ? ent_res_pc[head] : ent_pc[head] + 32'd4;
                    end
                end
                default: ;
            endcase
        end
    end

    // Control state and commit pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            ent_valid     <= '0;
            ent_ready     <= '0;
            reg_en        <= 1'b0;
            reg_rd        <= '0;
            reg_val       <= '0;
            reg_rob_pos   <= '0;
            st_commit_en  <= 1'b0;
            st_commit_pos <= '0;
            br_en         <= 1'b0;
            br_j          <= 1'b0;
            br_pc         <= '0;
            rollback      <= 1'b0;
            rollback_pc   <= '0;
        end else if (rdy) begin
            reg_en        <= c_reg_en;
            reg_rd        <= c_reg_rd;
            reg_val       <= c_reg_val;
            reg_rob_pos   <= c_reg_pos;
            st_commit_en  <= c_st_en;
            st_commit_pos <= c_st_pos;
            br_en         <= c_br_en;
            br_j          <= c_br_j;
            br_pc         <= c_br_pc;
            rollback      <= c_rb;
            rollback_pc   <= c_rb_pc;
            if (c_rb) begin
                head      <= '0;
                tail      <= '0;
                count     <= '0;
                ent_valid <= '0;
            end else begin
                if (issue_en) begin
                    ent_valid[tail] <= 1'b1;
                    ent_ready[tail] <= issue_ready;
                    tail            <= tail + POS_ONE;
                end
                if (alu_hit) ent_ready[alu_rob_pos] <= 1'b1;
                if (lsb_hit) ent_ready[lsb_rob_pos] <= 1'b1;
                if (do_commit) begin
                    ent_valid[head] <= 1'b0;
                    head            <= head + POS_ONE;
                end
                case ({issue_en, do_commit})
                    2'b10:   count <= count + CNT_ONE;
                    2'b01:   count <= count - CNT_ONE;
                    default: ;
                endcase
            end
        end
    end

    // Entry payload; validity is tracked by the control block above.
    always_ff @(posedge clk) begin
        if (rdy) begin
            if (issue_en) begin
                ent_type[tail]  <= issue_type;
                ent_rd[tail]    <= issue_rd;
                ent_pc[tail]    <= issue_pc;
                ent_pre_j[tail] <= issue_pre_j;
                ent_val[tail]   <= issue_val;
            end
            if (alu_hit) begin
                ent_val[alu_rob_pos]    <= alu_val;
                ent_res_j[alu_rob_pos]  <= alu_res_j;
                ent_res_pc[alu_rob_pos] <= alu_res_pc;
            end
            if (lsb_hit) ent_val[lsb_rob_pos] <= lsb_val;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: expected commit pulses are queued as stimulus
// is issued and a negedge monitor pops and compares every new pulse.
module tb_reorder_buffer;
    localparam int PW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1, rdy = 1'b1;
    logic          issue_en = 1'b0, issue_pre_j = 1'b0, issue_ready = 1'b0;
    logic [1:0]    issue_type = '0;
    logic [4:0]    issue_rd = '0;
    logic [31:0]   issue_pc = '0, issue_val = '0;
    logic [PW-1:0] rob_pos;
    logic          rob_full;
    logic          alu_en = 1'b0, alu_res_j = 1'b0;
    logic [PW-1:0] alu_rob_pos = '0;
    logic [31:0]   alu_val = '0, alu_res_pc = '0;
    logic          lsb_en = 1'b0;
    logic [PW-1:0] lsb_rob_pos = '0;
    logic [31:0]   lsb_val = '0;
    logic [PW-1:0] q1_pos = '0, q2_pos = '0;
    logic          q1_rdy, q2_rdy;
    logic [31:0]   q1_val, q2_val;
    logic          reg_en, st_commit_en, br_en, br_j, rollback;
    logic [4:0]    reg_rd;
    logic [31:0]   reg_val, br_pc, rollback_pc;
    logic [PW-1:0] reg_rob_pos, st_commit_pos;

    reorder_buffer #(.ROB_SIZE(16)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .issue_en(issue_en), .issue_type(issue_type), .issue_rd(issue_rd),
        .issue_pc(issue_pc), .issue_pre_j(issue_pre_j), .issue_ready(issue_ready),
        .issue_val(issue_val), .rob_pos(rob_pos), .rob_full(rob_full),
        .alu_en(alu_en), .alu_rob_pos(alu_rob_pos), .alu_val(alu_val),
        .alu_res_j(alu_res_j), .alu_res_pc(alu_res_pc),
        .lsb_en(lsb_en), .lsb_rob_pos(lsb_rob_pos), .lsb_val(lsb_val),
        .q1_pos(q1_pos), .q1_rdy(q1_rdy), .q1_val(q1_val),
        .q2_pos(q2_pos), .q2_rdy(q2_rdy), .q2_val(q2_val),
        .reg_en(reg_en), .reg_rd(reg_rd), .reg_val(reg_val), .reg_rob_pos(reg_rob_pos),
        .st_commit_en(st_commit_en), .st_commit_pos(st_commit_pos),
        .br_en(br_en), .br_j(br_j), .br_pc(br_pc),
        .rollback(rollback), .rollback_pc(rollback_pc)
    );

    typedef struct packed {
        logic          reg_en;
        logic [4:0]    reg_rd;
        logic [31:0]   reg_val;
        logic [PW-1:0] reg_pos;
        logic          st_en;
        logic [PW-1:0] st_pos;
        logic          br_en;
        logic          br_j;
        logic [31:0]   br_pc;
        logic          rb;
        logic [31:0]   rb_pc;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad = 0;
    logic edge_rdy = 1'b0, edge_rst = 1'b1;
    ev_t act_ev, exp_ev;

    function automatic ev_t ev_reg(logic [4:0] rd, logic [31:0] v, logic [PW-1:0] p,
                                   logic rb, logic [31:0] rbpc);
        ev_t e = '0;
        e.reg_en = 1'b1; e.reg_rd = rd; e.reg_val = v; e.reg_pos = p;
        e.rb = rb; e.rb_pc = rbpc;
        return e;
    endfunction

    function automatic ev_t ev_st(logic [PW-1:0] p);
        ev_t e = '0;
        e.st_en = 1'b1; e.st_pos = p;
        return e;
    endfunction

    function automatic ev_t ev_br(logic j, logic [31:0] pc, logic rb, logic [31:0] rbpc);
        ev_t e = '0;
        e.br_en = 1'b1; e.br_j = j; e.br_pc = pc; e.rb = rb; e.rb_pc = rbpc;
        return e;
    endfunction

    always @(posedge clk) begin
        edge_rdy <= rdy;
        edge_rst <= rst;
    end

    always @(negedge clk) begin
        act_ev = {reg_en, reg_rd, reg_val, reg_rob_pos, st_commit_en, st_commit_pos,
                  br_en, br_j, br_pc, rollback, rollback_pc};
        if (edge_rdy && !edge_rst && (reg_en || st_commit_en || br_en || rollback)) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL commit_unexpected got=%h want=none", act_ev);
            end else begin
                exp_ev = exp_q.pop_front();
                if (act_ev !== exp_ev) begin
                    bad++;
                    $display("FAIL commit_event got=%h want=%h", act_ev, exp_ev);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, a, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] pc,
                         input logic pj, input logic r, input logic [31:0] v);
        issue_en = 1'b1; issue_type = t; issue_rd = rd; issue_pc = pc;
        issue_pre_j = pj; issue_ready = r; issue_val = v;
        step();
        issue_en = 1'b0; issue_ready = 1'b0;
    endtask

    task automatic alu_wb(input logic [PW-1:0] p, input logic [31:0] v, input logic j,
                          input logic [31:0] rpc);
        alu_en = 1'b1; alu_rob_pos = p; alu_val = v; alu_res_j = j; alu_res_pc = rpc;
        step();
        alu_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        step(); step(); step();
        chk("reset_rob_pos", rob_pos, 0);
        chk("reset_rob_full", rob_full, 0);
        chk("reset_pulses", {reg_en, st_commit_en, br_en, rollback}, 0);
        rst = 1'b0;

        // In-order commit of three ready entries.
        exp_q.push_back(ev_reg(5'd1, 32'h11, 4'd0, 1'b0, 32'h0));
        exp_q.push_back(ev_reg(5'd2, 32'h22, 4'd1, 1'b0, 32'h0));
        exp_q.push_back(ev_reg(5'd3, 32'h33, 4'd2, 1'b0, 32'h0));
        issue(2'd0, 5'd1, 32'h0, 1'b0, 1'b1, 32'h11);
        issue(2'd0, 5'd2, 32'h4, 1'b0, 1'b1, 32'h22);
        issue(2'd0, 5'd3, 32'h8, 1'b0, 1'b1, 32'h33);
        chk("inorder_mid_reg_en", reg_en, 1);
        chk("inorder_mid_pos", reg_rob_pos, 1);
        step(); step(); step();
        chk("inorder_drained", reg_en, 0);

        // Out-of-order writeback.
        do_reset();
        issue(2'd0, 5'd4, 32'h0, 1'b0, 1'b0, 32'h0);
        issue(2'd0, 5'd5, 32'h4, 1'b0, 1'b0, 32'h0);
        alu_wb(4'd1, 32'd5, 1'b0, 32'h0);
        chk("ooo_no_early_commit", reg_en, 0);
        exp_q.push_back(ev_reg(5'd4, 32'd7, 4'd0, 1'b0, 32'h0));
        exp_q.push_back(ev_reg(5'd5, 32'd5, 4'd1, 1'b0, 32'h0));
        alu_wb(4'd0, 32'd7, 1'b0, 32'h0);
        chk("ooo_wait_edge", reg_en, 0);
        step();
        chk("ooo_first_pos", reg_rob_pos, 0);
        step();
        chk("ooo_second_pos", reg_rob_pos, 1);
        step();

        // Full threshold and tail wrap.
        do_reset();
        for (int i = 0; i < 15; i++) issue(2'd0, 5'(i), 32'h0, 1'b0, 1'b0, 32'h0);
        chk("full_set", rob_full, 1);
        chk("full_rob_pos", rob_pos, 15);
        exp_q.push_back(ev_reg(5'd0, 32'hA0, 4'd0, 1'b0, 32'h0));
        alu_wb(4'd0, 32'hA0, 1'b0, 32'h0);
        chk("full_before_commit", rob_full, 1);
        step();
        chk("full_drop", rob_full, 0);
        issue(2'd0, 5'd20, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("wrap_pos0", rob_pos, 0);
        issue(2'd0, 5'd21, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("wrap_pos1", rob_pos, 1);

        // Mispredict not-taken -> taken, with an issue on the rollback edge.
        do_reset();
        issue(2'd1, 5'd0, 32'h100, 1'b0, 1'b0, 32'h0);
        issue(2'd0, 5'd8, 32'h104, 1'b0, 1'b1, 32'h81);
        issue(2'd0, 5'd9, 32'h108, 1'b0, 1'b1, 32'h91);
        exp_q.push_back(ev_br(1'b1, 32'h100, 1'b1, 32'h180));
        alu_wb(4'd0, 32'h0, 1'b1, 32'h180);
        issue(2'd0, 5'd10, 32'h10C, 1'b0, 1'b1, 32'hA1);
        chk("mis_rollback", rollback, 1);
        chk("mis_rollback_pc", rollback_pc, 32'h180);
        chk("mis_issue_discard", rob_pos, 0);
        step();
        chk("mis_rollback_clear", rollback, 0);
        chk("mis_rob_pos", rob_pos, 0);
        chk("mis_rob_full", rob_full, 0);
        step(); step(); step();

        // Mispredict taken -> not taken.
        do_reset();
        issue(2'd1, 5'd0, 32'h100, 1'b1, 1'b0, 32'h0);
        issue(2'd0, 5'd8, 32'h104, 1'b0, 1'b1, 32'h81);
        issue(2'd0, 5'd9, 32'h108, 1'b0, 1'b1, 32'h91);
        exp_q.push_back(ev_br(1'b0, 32'h100, 1'b1, 32'h104));
        alu_wb(4'd0, 32'h0, 1'b0, 32'h180);
        step();
        chk("mis2_rollback_pc", rollback_pc, 32'h104);
        step(); step(); step();

        // Store, correctly predicted branch, jalr; dual writeback in one cycle.
        do_reset();
        issue(2'd2, 5'd0, 32'h200, 1'b0, 1'b0, 32'h0);
        issue(2'd1, 5'd0, 32'h204, 1'b1, 1'b0, 32'h0);
        issue(2'd3, 5'd1, 32'h208, 1'b0, 1'b0, 32'h0);
        issue(2'd0, 5'd12, 32'h20C, 1'b0, 1'b1, 32'hC);
        exp_q.push_back(ev_st(4'd0));
        exp_q.push_back(ev_br(1'b1, 32'h204, 1'b0, 32'h0));
        exp_q.push_back(ev_reg(5'd1, 32'h20C, 4'd2, 1'b1, 32'h500));
        lsb_en = 1'b1; lsb_rob_pos = 4'd0; lsb_val = 32'h0;
        alu_wb(4'd1, 32'h0, 1'b1, 32'h300);
        lsb_en = 1'b0;
        alu_wb(4'd2, 32'h20C, 1'b0, 32'h500);
        for (int k = 0; k < 5; k++) step();
        chk("jalr_flush_pos", rob_pos, 0);

        // Query bypass priority.
        do_reset();
        for (int i = 0; i < 4; i++) issue(2'd0, 5'(i + 1), 32'h0, 1'b0, 1'b0, 32'h0);
        q1_pos = 4'd3; q2_pos = 4'd2;
        alu_en = 1'b1; alu_rob_pos = 4'd3; alu_val = 32'hDEAD;
        #1;
        chk("q1_alu_rdy", q1_rdy, 1);
        chk("q1_alu_val", q1_val, 32'hDEAD);
        chk("q2_unready", q2_rdy, 0);
        lsb_en = 1'b1; lsb_rob_pos = 4'd3; lsb_val = 32'hBEEF;
        #1;
        chk("q1_alu_wins", q1_val, 32'hDEAD);
        alu_en = 1'b0;
        #1;
        chk("q1_lsb_rdy", q1_rdy, 1);
        chk("q1_lsb_val", q1_val, 32'hBEEF);
        lsb_en = 1'b0;
        #1;
        chk("q1_no_bus", q1_rdy, 0);
        alu_wb(4'd2, 32'h55, 1'b0, 32'h0);
        chk("q2_stored_rdy", q2_rdy, 1);
        chk("q2_stored_val", q2_val, 32'h55);

        // Stall with a ready head.
        do_reset();
        issue(2'd0, 5'd7, 32'h0, 1'b0, 1'b1, 32'h77);
        rdy = 1'b0;
        issue_en = 1'b1; issue_rd = 5'd9; issue_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_no_pulse", reg_en, 0);
            chk("stall_rob_pos", rob_pos, 1);
        end
        issue_en = 1'b0; issue_ready = 1'b0;
        exp_q.push_back(ev_reg(5'd7, 32'h77, 4'd0, 1'b0, 32'h0));
        rdy = 1'b1;
        step();
        chk("stall_release_commit", reg_en, 1);
        rdy = 1'b0;
        step();
        chk("stall_pulse_held", reg_en, 1);
        chk("stall_held_val", reg_val, 32'h77);
        rdy = 1'b1;
        step();
        chk("stall_pulse_end", reg_en, 0);

        // Reset mid-run beats rdy low and an imminent commit.
        exp_q.push_back(ev_reg(5'd1, 32'h1, 4'd1, 1'b0, 32'h0));
        exp_q.push_back(ev_reg(5'd2, 32'h2, 4'd2, 1'b0, 32'h0));
        issue(2'd0, 5'd1, 32'h0, 1'b0, 1'b1, 32'h1);
        issue(2'd0, 5'd2, 32'h0, 1'b0, 1'b1, 32'h2);
        issue(2'd0, 5'd3, 32'h0, 1'b0, 1'b1, 32'h3);
        rst = 1'b1; rdy = 1'b0;
        step();
        chk("rst_rob_pos", rob_pos, 0);
        chk("rst_rob_full", rob_full, 0);
        chk("rst_outputs", {reg_en, reg_rd, reg_val, st_commit_en, br_en, rollback}, 0);
        rst = 1'b0; rdy = 1'b1;
        step(); step(); step();
        chk("rst_no_commit", reg_en, 0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Circular reorder buffer directly downstream of `Decoder`. It allocates one entry per issued instruction, hands the tail index back to the decoder as `rob_pos`, and collects out-of-order results from the ALU and LSB broadcast buses. It retires entries strictly in program order, one per cycle, to the register file or the LSB store path. At branch or `jalr` retirement it feeds back to `IFetch`, and it drives the global `rollback` used by `MemCtrl`, `IFetch`, `Decoder`, the RS and the LSB.

## Interface
- `ROB_SIZE`, 16: entry count; must be a power of two. `PW = $clog2(ROB_SIZE)`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rdy` in 1: when low, all state and all outputs hold.
- `issue_en` in 1: allocate an entry at the tail this cycle.
- `issue_type` in 2: 0 = reg write, 1 = branch, 2 = store, 3 = jalr.
- `issue_rd` in 5: destination register.
- `issue_pc` in 32: PC of the issued instruction.
- `issue_pre_j` in 1: predicted taken.
- `issue_ready` in 1: result is already known at issue (lui/auipc/jal).
- `issue_val` in 32: value written when `issue_ready` is 1.
- `rob_pos` out PW: current tail index, i.e. the slot the next issue will receive.
- `rob_full` out 1: asserted when count ≥ ROB_SIZE−1.
- `alu_en` in 1, `alu_rob_pos` in PW, `alu_val` in 32, `alu_res_j` in 1, `alu_res_pc` in 32: ALU result broadcast.
- `lsb_en` in 1, `lsb_rob_pos` in PW, `lsb_val` in 32: LSB result broadcast (loads carry data; stores signal address and data ready).
- `q1_pos` in PW, `q1_rdy` out 1, `q1_val` out 32: combinational operand query port 1 from the decoder.
- `q2_pos` in PW, `q2_rdy` out 1, `q2_val` out 32: operand query port 2, same rules.
- `reg_en` out 1, `reg_rd` out 5, `reg_val` out 32, `reg_rob_pos` out PW: commit to the register file.
- `st_commit_en` out 1, `st_commit_pos` out PW: the store at this position may now write memory.
- `br_en` out 1, `br_j` out 1, `br_pc` out 32: branch outcome returned to the IFetch predictor.
- `rollback` out 1, `rollback_pc` out 32: flush request and redirect target.

## Operation
- Each entry holds: valid, ready, type, rd, pc, pre_j, val, res_j, res_pc. The buffer keeps head, tail (PW bits each, wrap naturally) and count (PW+1 bits).
- **Issue:** when `issue_en` is high, write the entry at the tail with ready = `issue_ready` and val = `issue_val`, then tail+1.
- **Writeback:** `alu_en` or `lsb_en` sets the addressed entry to ready and stores val. `alu_en` also stores res_j and res_pc. Both buses may be active in the same cycle on different positions. A writeback to an invalid entry is ignored.
- **Commit:** evaluated when the head entry is valid and ready; at most one commit per cycle. Action by type:
  - Type 0 and type 3: pulse `reg_en` with rd, val and head position. A write with rd = 0 is still pulsed; the register file drops it.
  - Type 2: pulse `st_commit_en` with the head position.
  - Type 1: pulse `br_en` with `br_j` = res_j and `br_pc` = pc. If res_j ≠ pre_j, trigger rollback with `rollback_pc` = res_pc when res_j is 1, otherwise pc+4.
  - Type 3: always triggers rollback with `rollback_pc` = res_pc.
- **Rollback:** registered one-cycle pulse. On the same edge, head, tail and count return to 0 and every valid bit is cleared. `issue_en` and writebacks sampled on that edge are discarded.
- **Count:** count += issue − commit; a simultaneous issue and commit leaves count unchanged.
- **Query:** the `qN_rdy`/`qN_val` source is chosen in this priority order:
  1. the `alu_en` bus when `alu_rob_pos` matches `qN_pos`;
  2. the `lsb_en` bus when `lsb_rob_pos` matches `qN_pos`;
  3. the stored entry's ready and val.
- **Reset:** head, tail and count are 0; every valid bit is 0; every output is 0 (`rob_full` is 0).

## Timing
- All commit outputs (`reg_*`, `st_commit_*`, `br_*`, `rollback*`) are registered one-cycle pulses, low in every cycle without a commit.
- An entry issued with `issue_ready` = 1 at edge E commits on edge E+1; its pulse is visible during the cycle after E+1.
- A writeback sampled at edge E makes a head entry commit on edge E+1.
- `rob_pos` and `rob_full` derive from registered state only. The ROB_SIZE−1 threshold on `rob_full` gives one cycle of slack for an issue already in flight.
- While `rdy` is low, nothing changes and pulses hold their values; consumers are frozen as well.
- The `rst` reset takes priority over `rdy` and `rollback`.

## Test plan
- **In-order commit:** reset, then issue three type-0 ready entries (rd 1/2/3, values 0x11/0x22/0x33) on consecutive cycles → `reg_en` high for 3 consecutive cycles with `reg_rob_pos` 0, 1, 2 and the matching rd/val.
- **Out-of-order writeback:** issue unready entries at pos 0 and 1; ALU writes pos 1 = 5, then next cycle pos 0 = 7 → no commit before the pos 0 writeback; then pos 0 (7) and pos 1 (5) commit on back-to-back cycles.
- **Full and wrap:** issue 15 unready entries → `rob_full` = 1, `rob_pos` = 15. Write back pos 0 → commit; `rob_full` drops. Issue 2 more → `rob_pos` wraps 15 → 0 → 1.
- **Mispredict:** type-1 entry with pc 0x100, pre_j = 0, followed by 2 younger entries; ALU returns res_j = 1, res_pc = 0x180 → `br_en` = 1, `br_j` = 1, `rollback` = 1, `rollback_pc` = 0x180 for one cycle. The next cycle shows `rob_pos` = 0, `rob_full` = 0, and the younger entries never commit. Repeat with res_j = 0 and pre_j = 1 → `rollback_pc` = 0x104.
- **Query bypass:** `q1_pos` = 3 on an unready entry with `alu_en`, pos 3, val 0xDEAD in the same cycle → `q1_rdy` = 1, `q1_val` = 0xDEAD. Simultaneous LSB hit at pos 3 → the ALU value wins.
- **Stall and reset:** with a ready head, hold `rdy` low for 3 cycles → no state change and no new pulse; then raise `rdy` → commit. Assert `rst` mid-run → all outputs and count are 0 on the next cycle.
